// File: rtl/sr_drv_pkg.sv
// ============================================================================
// Module  : sr_drv_pkg
// Brief   : Shared types and constants for the gated SR latch driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Counter width must hold the longest phase length minus one.
    function automatic int calc_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_phase_timer.sv
// ============================================================================
// Module  : sr_phase_timer
// Brief   : Loadable down-counter that times one driver phase at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sr_latch_driver.sv
// ============================================================================
// Module  : sr_latch_driver
// Brief   : Sequences set/clear commands into a setup/pulse/hold envelope on
//           the S, R and enable pins of a gated SR latch.
//           Optional Q readback check enabled by defining SRDRV_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_op,
    output logic cmd_ready,
    output logic lat_s,
    output logic lat_r,
    output logic lat_en,
    output logic busy,
    output logic done,
    input  logic q_in,
    output logic rb_err,
    output logic rb_err_sticky
);

    localparam int CNT_W = calc_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_op;
    logic             w_op_nxt;
    logic             r_lat_s;
    logic             r_lat_r;
    logic             r_lat_en;
    logic             r_busy;
    logic             r_done;
    logic             w_lat_s_nxt;
    logic             w_lat_r_nxt;
    logic             w_lat_en_nxt;
    logic             w_done_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_count;
    logic             w_zero;

    sr_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .count    (w_count),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_CLR;
            r_lat_s  <= 1'b0;
            r_lat_r  <= 1'b0;
            r_lat_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_lat_s  <= w_lat_s_nxt;
            r_lat_r  <= w_lat_r_nxt;
            r_lat_en <= w_lat_en_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_load      = 1'b0;
        w_load_val  = C_SETUP_LD;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = SETUP;
                    w_op_nxt    = cmd_op;
                    w_load      = 1'b1;
                    w_load_val  = C_SETUP_LD;
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_state_nxt = PULSE;
                    w_load      = 1'b1;
                    w_load_val  = C_PULSE_LD;
                end
            end
            PULSE: begin
                if (w_zero) begin
                    w_state_nxt = HOLD;
                    w_load      = 1'b1;
                    w_load_val  = C_HOLD_LD;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so every pin is a flop;
        // S and R only move on SETUP entry and IDLE return, both with enable low.
        w_lat_s_nxt  = (w_state_nxt != IDLE) && (w_op_nxt == OP_SET);
        w_lat_r_nxt  = (w_state_nxt != IDLE) && (w_op_nxt == OP_CLR);
        w_lat_en_nxt = (w_state_nxt == PULSE);
        w_done_nxt   = ((r_state == PULSE) && w_zero && (HOLD_CYC == 1)) ||
                       ((r_state == HOLD) && (w_count == C_ONE));
    end

    assign cmd_ready = ~r_busy;
    assign busy      = r_busy;
    assign lat_s     = r_lat_s;
    assign lat_r     = r_lat_r;
    assign lat_en    = r_lat_en;
    assign done      = r_done;

`ifdef SRDRV_READBACK_EN
    logic r_rb_sticky;
    logic w_rb_err;

    // The latch has had the whole pulse plus hold to settle by the final HOLD cycle.
    assign w_rb_err = r_done && (q_in != r_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb_sticky <= 1'b0;
        end else if (w_rb_err) begin
            r_rb_sticky <= 1'b1;
        end
    end

    assign rb_err        = w_rb_err;
    assign rb_err_sticky = r_rb_sticky;
`else
    logic w_unused_q_in;
    assign w_unused_q_in = q_in;
    assign rb_err        = 1'b0;
    assign rb_err_sticky = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ============================================================================
// Module  : tb_sr_latch_driver
// Brief   : Self-checking bench for sr_latch_driver (SRDRV_READBACK_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_driver;

    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 4;
    localparam int HOLD_CYC  = 1;
    localparam int TOTAL     = SETUP_CYC + PULSE_CYC + HOLD_CYC;
`ifdef SRDRV_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_op = 1'b0;
    logic q_in = 1'b0;
    logic cmd_ready, lat_s, lat_r, lat_en, busy, done, rb_err, rb_err_sticky;

    int n_vec = 0;
    int n_bad = 0;

    sr_latch_driver #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_ready     (cmd_ready),
        .lat_s         (lat_s),
        .lat_r         (lat_r),
        .lat_en        (lat_en),
        .busy          (busy),
        .done          (done),
        .q_in          (q_in),
        .rb_err        (rb_err),
        .rb_err_sticky (rb_err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_k counts cycles since accept (0 means idle); phases are ranges of m_k.
    int   m_k = 0;
    logic m_op = 1'b0;
    logic m_sticky = 1'b0;
    logic m_rst_seen = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k        = 0;
            m_sticky   = 1'b0;
            m_rst_seen = 1'b1;
        end else begin
            if (RB && m_k == TOTAL && q_in != m_op) m_sticky = 1'b1;
            if (m_k == 0) begin
                if (cmd_valid) begin
                    m_k  = 1;
                    m_op = cmd_op;
                end
            end else if (m_k == TOTAL) begin
                m_k = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
    end

    logic p_s = 1'b0, p_r = 1'b0, p_en = 1'b0;

    always @(negedge clk) begin
        logic act_busy, e_en, e_done;
        act_busy = (m_k != 0);
        e_en     = (m_k > SETUP_CYC) && (m_k <= SETUP_CYC + PULSE_CYC);
        e_done   = (m_k == TOTAL);
        check("lat_s",     lat_s,     act_busy && m_op);
        check("lat_r",     lat_r,     act_busy && !m_op);
        check("lat_en",    lat_en,    e_en);
        check("busy",      busy,      act_busy);
        check("cmd_ready", cmd_ready, !act_busy);
        check("done",      done,      e_done);
        check("rb_err",    rb_err,    RB && e_done && (q_in != m_op));
        check("rb_sticky", rb_err_sticky, m_sticky);
        check("s_r_exclusive", lat_s && lat_r, 1'b0);
        if (!m_rst_seen && ((lat_s !== p_s) || (lat_r !== p_r)))
            check("sr_change_en_low", lat_en || p_en, 1'b0);
        p_s = lat_s;
        p_r = lat_r;
        p_en = lat_en;
        m_rst_seen = 1'b0;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(2);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_s",     lat_s,     1'b0);
        check("rst_r",     lat_r,     1'b0);
        check("rst_en",    lat_en,    1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        check("rst_sticky", rb_err_sticky, 1'b0);
        rst_n = 1'b1;
        cyc(1);

        // Set command with q_in stuck low, presented in cycle 0.
        cmd_valid = 1'b1; cmd_op = 1'b1; q_in = 1'b0;
        cyc(1);
        check("set_c1_s",     lat_s,     1'b1);
        check("set_c1_en",    lat_en,    1'b0);
        check("set_c1_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        cyc(1);
        check("set_c2_en", lat_en, 1'b1);
        cyc(3);
        check("set_c5_en", lat_en, 1'b1);
        cyc(1);
        check("set_c6_en",   lat_en, 1'b0);
        check("set_c6_done", done,   1'b1);
        check("set_c6_rb",   rb_err, RB);
        cyc(1);
        check("set_c7_ready",  cmd_ready,     1'b1);
        check("set_c7_s",      lat_s,         1'b0);
        check("set_c7_sticky", rb_err_sticky, RB);

        // Valid held with op toggling: only the cycle-0 op runs, next accept at cycle 7.
        q_in = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            if (c == 1) check("hold_c1_s", lat_s, 1'b1);
            if (c == 4) check("hold_c4_s", lat_s, 1'b1);
            if (c == 7) check("hold_c7_ready", cmd_ready, 1'b1);
            if (c == 8) begin
                check("hold_c8_r",    lat_r, 1'b1);
                check("hold_c8_busy", busy,  1'b1);
            end
            cmd_op = ~cmd_op;
        end
        cmd_valid = 1'b0;
        cyc(7);
        check("hold_sticky_kept", rb_err_sticky, RB);

        // Asynchronous reset in the middle of PULSE.
        cmd_valid = 1'b1; cmd_op = 1'b0;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        check("pre_rst_en", lat_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_en",     lat_en,        1'b0);
        check("async_r",      lat_r,         1'b0);
        check("async_busy",   busy,          1'b0);
        check("async_ready",  cmd_ready,     1'b1);
        check("async_sticky", rb_err_sticky, 1'b0);
        #3 rst_n = 1'b1;
        cyc(1);
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_busy",  busy,      1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 1'($urandom_range(0, 1));
            q_in      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            cyc(1);
        end
        cmd_valid = 1'b0;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
